alu_share_ctrl: RTL and testbench

ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

---
 rtl/alu_share_if.sv | 32 +++
 rtl/alu_share_ctrl.sv | 97 +++++++++
 tb/tb_alu_share_ctrl.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_if.sv
// Requester, response and ALU-side signals of the shared-ALU controller.
// The slave modport is the controller's view; master is the environment's view.
interface alu_share_if #(
  parameter int DATA_WIDTH = 16,
  parameter int FUN_WIDTH  = 4
);
  logic                  req0_valid, req1_valid;
  logic [FUN_WIDTH-1:0]  req0_fun, req1_fun;
  logic [DATA_WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic                  req0_ready, req1_ready;
  logic                  resp0_valid, resp1_valid;
  logic [DATA_WIDTH-1:0] resp_data;
  logic [DATA_WIDTH-1:0] alu_a, alu_b;
  logic [1:0]            alu_fun;
  logic                  arith_en, logic_en, cmp_en, shift_en;
  logic [DATA_WIDTH-1:0] alu_out;
  logic                  busy;

  modport slave (
    input  req0_valid, req1_valid, req0_fun, req1_fun,
           req0_a, req0_b, req1_a, req1_b, alu_out,
    output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data,
           alu_a, alu_b, alu_fun, arith_en, logic_en, cmp_en, shift_en, busy
  );

  modport master (
    output req0_valid, req1_valid, req0_fun, req1_fun,
           req0_a, req0_b, req1_a, req1_b, alu_out,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_data,
           alu_a, alu_b, alu_fun, arith_en, logic_en, cmp_en, shift_en, busy
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Arbitrates two requesters onto a set of registered ALU units, one operation
// in flight at a time: accept (IDLE) -> enable unit (EXEC) -> capture (CAPTURE).
module alu_share_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int FUN_WIDTH  = 4
) (
  input  logic        clk,
  input  logic        async_rst,
  alu_share_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPTURE} state_t;

  state_t                state, state_nxt;
  logic                  last_grant;
  logic                  owner;
  logic                  grant;
  logic                  handshake;
  logic [FUN_WIDTH-1:0]  fun_q;
  logic [DATA_WIDTH-1:0] op_a, op_b;
  logic [DATA_WIDTH-1:0] resp_q;
  logic                  resp0_q, resp1_q;

  // Tie goes to the requester that did not win last time.
  assign grant     = bus.req1_valid && (!bus.req0_valid || !last_grant);
  assign handshake = (state == IDLE) && (bus.req0_valid || bus.req1_valid);

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.arith_en   = 1'b0;
    bus.logic_en   = 1'b0;
    bus.cmp_en     = 1'b0;
    bus.shift_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (handshake) begin
          bus.req0_ready = !grant;
          bus.req1_ready = grant;
          state_nxt      = EXEC;
        end
      end
      EXEC: begin
        unique case (fun_q[3:2])
          2'b00: bus.arith_en = 1'b1;
          2'b01: bus.logic_en = 1'b1;
          2'b10: bus.cmp_en   = 1'b1;
          2'b11: bus.shift_en = 1'b1;
        endcase
        state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of the order of statements.
  always_ff @(posedge clk or negedge async_rst) begin
    if (!async_rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      fun_q      <= '0;
      op_a       <= '0;
      op_b       <= '0;
      resp_q     <= '0;
      resp0_q    <= 1'b0;
      resp1_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (handshake) begin
        last_grant <= grant;
        owner      <= grant;
        fun_q      <= grant ? bus.req1_fun : bus.req0_fun;
        op_a       <= grant ? bus.req1_a   : bus.req0_a;
        op_b       <= grant ? bus.req1_b   : bus.req0_b;
      end
      if (state == CAPTURE) resp_q <= bus.alu_out;
      resp0_q <= (state == CAPTURE) && !owner;
      resp1_q <= (state == CAPTURE) && owner;
    end
  end

  // Operands stay on the ALU buses between operations to avoid needless toggling.
  assign bus.alu_a       = op_a;
  assign bus.alu_b       = op_b;
  assign bus.alu_fun     = fun_q[1:0];
  assign bus.resp_data   = resp_q;
  assign bus.resp0_valid = resp0_q;
  assign bus.resp1_valid = resp1_q;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Randomized bench for alu_share_ctrl: acts as the registered ALU units and
// predicts every output from handshake timestamps and arithmetic results.
module tb_alu_share_ctrl;

  logic clk = 1'b0;
  logic async_rst;
  always #5 clk = ~clk;

  alu_share_if #(.DATA_WIDTH(16), .FUN_WIDTH(4)) bus ();

  alu_share_ctrl #(.DATA_WIDTH(16), .FUN_WIDTH(4)) dut (
    .clk       (clk),
    .async_rst (async_rst),
    .bus       (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_alu(input logic [3:0] fn, input logic [15:0] x, input logic [15:0] y);
    case (fn)
      4'h0: return x + y;
      4'h1: return x - y;
      4'h2: return x + 16'd1;
      4'h3: return x - 16'd1;
      4'h4: return x & y;
      4'h5: return x | y;
      4'h6: return x ^ y;
      4'h7: return ~x;
      4'h8: return {15'd0, x == y};
      4'h9: return {15'd0, x < y};
      4'hA: return {15'd0, x > y};
      4'hB: return {15'd0, $signed(x) < $signed(y)};
      4'hC: return x << y[3:0];
      4'hD: return x >> y[3:0];
      4'hE: return 16'($signed(x) >>> y[3:0]);
      default: return {x[14:0], x[15]};
    endcase
  endfunction

  // Registered ALU units; garbage on alu_out whenever no unit is enabled.
  logic [3:0] en;
  assign en = {bus.shift_en, bus.cmp_en, bus.logic_en, bus.arith_en};
  always @(posedge clk) begin
    case (en)
      4'b0001: bus.alu_out <= ref_alu({2'd0, bus.alu_fun}, bus.alu_a, bus.alu_b);
      4'b0010: bus.alu_out <= ref_alu({2'd1, bus.alu_fun}, bus.alu_a, bus.alu_b);
      4'b0100: bus.alu_out <= ref_alu({2'd2, bus.alu_fun}, bus.alu_a, bus.alu_b);
      4'b1000: bus.alu_out <= ref_alu({2'd3, bus.alu_fun}, bus.alu_a, bus.alu_b);
      default: bus.alu_out <= 16'($urandom);
    endcase
  end

  // Requester stimulus for the next cycle.
  bit          v [2];
  logic [3:0]  f [2];
  logic [15:0] a [2];
  logic [15:0] b [2];

  // Reference model: one op described by its handshake cycle and result.
  int          cyc = 0;
  bit          op_live = 1'b0;
  int          hs_at = 0;
  bit          op_owner = 1'b0;
  logic [3:0]  op_fun = '0;
  logic [15:0] op_res = '0;
  bit          lg = 1'b1;
  logic [15:0] exp_a = '0, exp_b = '0, exp_rd = '0;

  task automatic model_reset();
    op_live = 1'b0;
    lg      = 1'b1;
    exp_a   = '0;
    exp_b   = '0;
    exp_rd  = '0;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < 2; i++) begin
      f[i] = 4'($urandom);
      a[i] = 16'($urandom);
      b[i] = 16'($urandom);
    end
  endtask

  // Called just after a falling edge: drive, settle, compare, advance model.
  task automatic apply_check();
    int age;
    bit idle, any, w;
    logic [3:0] exp_en;
    bus.req0_valid = v[0]; bus.req0_fun = f[0]; bus.req0_a = a[0]; bus.req0_b = b[0];
    bus.req1_valid = v[1]; bus.req1_fun = f[1]; bus.req1_a = a[1]; bus.req1_b = b[1];
    #1;
    age  = op_live ? (cyc - hs_at) : 99;
    idle = (age >= 3);
    any  = v[0] || v[1];
    w    = (v[0] && v[1]) ? !lg : v[1];
    if (age == 3) exp_rd = op_res;
    exp_en = (age == 1) ? 4'(1 << op_fun[3:2]) : 4'd0;
    check("req0_ready", bus.req0_ready, idle && any && !w);
    check("req1_ready", bus.req1_ready, idle && any && w);
    check("busy", bus.busy, (age == 1) || (age == 2));
    check("enables", en, exp_en);
    if (age == 1) check("alu_fun", bus.alu_fun, op_fun[1:0]);
    check("resp0_valid", bus.resp0_valid, (age == 3) && !op_owner);
    check("resp1_valid", bus.resp1_valid, (age == 3) && op_owner);
    check("resp_data", bus.resp_data, exp_rd);
    check("alu_a", bus.alu_a, exp_a);
    check("alu_b", bus.alu_b, exp_b);
    if (idle && any) begin
      op_live  = 1'b1;
      hs_at    = cyc;
      op_owner = w;
      op_fun   = f[w];
      op_res   = ref_alu(f[w], a[w], b[w]);
      exp_a    = a[w];
      exp_b    = b[w];
      lg       = w;
    end
    cyc++;
  endtask

  task automatic cycle();
    @(negedge clk);
    apply_check();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_enables"}, en, 0);
    check({tag, "_alu_a"}, bus.alu_a, 0);
    check({tag, "_alu_b"}, bus.alu_b, 0);
    check({tag, "_alu_fun"}, bus.alu_fun, 0);
    check({tag, "_resp_data"}, bus.resp_data, 0);
    check({tag, "_resp_valid"}, {bus.resp1_valid, bus.resp0_valid}, 0);
  endtask

  initial begin
    v = '{0, 0};
    f = '{4'd0, 4'd0};
    a = '{16'd0, 16'd0};
    b = '{16'd0, 16'd0};
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_fun = '0; bus.req1_fun = '0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
    async_rst = 1'b1;
    #2 async_rst = 1'b0;
    #1 check_all_zero("reset");

    // Ties straight out of reset: requester 0 first, then alternating.
    repeat (2) @(negedge clk);
    async_rst = 1'b1;
    v = '{1, 1};
    rand_ops();
    apply_check();
    repeat (11) begin
      rand_ops();
      cycle();
    end

    // Logic AND on requester 0; its inputs change while the op is in flight.
    v = '{0, 0};
    repeat (3) cycle();
    v[0] = 1'b1; f[0] = 4'b0100; a[0] = 16'hF0F0; b[0] = 16'hFF00;
    cycle();
    v[0] = 1'b0; a[0] = 16'h1234; b[0] = 16'h5678;
    repeat (3) cycle();
    check("and_resp_data", bus.resp_data, 16'hF000);

    // Unit decode sweep.
    for (int u = 0; u < 4; u++) begin
      v = '{1, 0};
      rand_ops();
      f[0] = 4'(u * 4 + int'($urandom_range(0, 3)));
      cycle();
      v = '{0, 0};
      repeat (2) cycle();
    end

    // Random traffic with withdrawn requests and changing operands.
    repeat (400) begin
      v[0] = ($urandom_range(0, 2) != 0);
      v[1] = ($urandom_range(0, 2) != 0);
      rand_ops();
      cycle();
    end

    // Reset while the unit is enabled aborts the op without a response.
    v = '{0, 0};
    repeat (3) cycle();
    v[1] = 1'b1;
    rand_ops();
    cycle();
    v = '{0, 0};
    cycle();
    async_rst = 1'b0;
    #1 check_all_zero("midop");
    check("midop_ready", {bus.req1_ready, bus.req0_ready}, 0);
    model_reset();
    @(negedge clk);
    async_rst = 1'b1;
    apply_check();
    repeat (5) cycle();

    // Post-reset tie still favours requester 0.
    v = '{1, 1};
    rand_ops();
    repeat (6) cycle();
    v = '{0, 0};
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
